// File: rtl/lzc_iter.sv
// lzc_iter: iterates over the set bits of an accepted vector, emitting one
// bit index per output handshake, LSB-first (MODE=0) or MSB-first (MODE=1).
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_i        synchronous active-high reset
//   flush_i      synchronous abort of the vector being scanned
//   in_valid_i   input vector valid
//   in_ready_o   input vector accepted when high together with in_valid_i
//   in_data_i    vector to iterate (WIDTH bits)
//   out_valid_o  an index is available
//   out_ready_i  consumer takes the index
//   out_idx_o    bit position in the original in_data_i numbering
//   out_ord_o    ordinal of this index within the current vector
//   out_last_o   this is the final set bit of the vector
//   zero_o       one-cycle pulse after an all-zero vector was accepted
module lzc_iter #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned IDX_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [IDX_WIDTH-1:0] out_idx_o,
  output logic [IDX_WIDTH-1:0] out_ord_o,
  output logic                 out_last_o,
  output logic                 zero_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       pending_q, pending_d;
  logic [IDX_WIDTH-1:0]   ord_q, ord_d;
  logic                   zero_q, zero_d;

  logic [IDX_WIDTH-1:0]   sel_idx;
  logic [WIDTH-1:0]       sel_onehot;
  logic                   sel_last;
  logic                   accept;
  logic                   beat;

  // Single-cycle priority encoder over pending; the last match in loop
  // order wins, so the loop runs opposite to the desired priority.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    if (MODE == 1'b0) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          sel_idx    = IDX_WIDTH'(i);
          sel_onehot = WIDTH'(1) << i;
        end
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (pending_q[i]) begin
          sel_idx    = IDX_WIDTH'(i);
          sel_onehot = WIDTH'(1) << i;
        end
      end
    end
  end

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign sel_last = (pending_q != '0) &&
                    ((pending_q & (pending_q - WIDTH'(1))) == '0);

  // Output view; everything reads zero outside SCAN.
  always_comb begin
    out_valid_o = (state_q == SCAN);
    out_idx_o   = (state_q == SCAN) ? sel_idx  : '0;
    out_ord_o   = (state_q == SCAN) ? ord_q    : '0;
    out_last_o  = (state_q == SCAN) ? sel_last : 1'b0;
  end

  // A new vector is taken when idle, or on the final beat so the next
  // vector's first index follows without a bubble.
  assign beat       = out_valid_o & out_ready_i;
  assign in_ready_o = ~flush_i &
                      ((state_q == IDLE) | ((state_q == SCAN) & sel_last & out_ready_i));
  assign accept     = in_valid_i & in_ready_o;
  assign zero_o     = zero_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ord_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ord_q     <= ord_d;
      zero_q    <= zero_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ord_d     = ord_q;
    zero_d    = 1'b0;

    if (flush_i) begin
      state_d   = IDLE;
      pending_d = '0;
      ord_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (in_data_i != '0) begin
              pending_d = in_data_i;
              ord_d     = '0;
              state_d   = SCAN;
            end else begin
              zero_d = 1'b1;
            end
          end
        end

        SCAN: begin
          if (beat) begin
            pending_d = pending_q & ~sel_onehot;
            ord_d     = ord_q + IDX_WIDTH'(1);
            if (sel_last) begin
              ord_d   = '0;
              state_d = IDLE;
              if (accept) begin
                if (in_data_i != '0) begin
                  pending_d = in_data_i;
                  state_d   = SCAN;
                end else begin
                  zero_d = 1'b1;
                end
              end
            end
          end
        end

        default: begin
          state_d   = IDLE;
          pending_d = '0;
          ord_d     = '0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Simulation-only sanity checks.
  a_width_pos: assert property (@(posedge clk_i) WIDTH > 0);

  a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i && !flush_i) |=>
      (out_valid_o && $stable(out_idx_o) && $stable(out_ord_o) && $stable(out_last_o)));

  a_idx_pending: assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> (((pending_q >> out_idx_o) & WIDTH'(1)) != '0));
`endif

endmodule

// File: tb/tb_lzc_iter.sv
// Directed bench for lzc_iter: four instances (8-bit LSB-first, 8-bit
// MSB-first, 1-bit, 5-bit MSB-first) share the control inputs.
module tb_lzc_iter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data8 = '0;
  logic [0:0] in_data1 = '0;
  logic [4:0] in_data5 = '0;

  logic       l_ready, l_ov, l_last, l_zero;
  logic [2:0] l_idx, l_ord;
  logic       m_ready, m_ov, m_last, m_zero;
  logic [2:0] m_idx, m_ord;
  logic       w1_ready, w1_ov, w1_last, w1_zero;
  logic [0:0] w1_idx, w1_ord;
  logic       w5_ready, w5_ov, w5_last, w5_zero;
  logic [2:0] w5_idx, w5_ord;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lzc_iter #(.WIDTH(8), .MODE(1'b0)) u_l8 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(l_ready), .in_data_i(in_data8),
    .out_valid_o(l_ov), .out_ready_i(out_ready), .out_idx_o(l_idx),
    .out_ord_o(l_ord), .out_last_o(l_last), .zero_o(l_zero));

  lzc_iter #(.WIDTH(8), .MODE(1'b1)) u_m8 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(m_ready), .in_data_i(in_data8),
    .out_valid_o(m_ov), .out_ready_i(out_ready), .out_idx_o(m_idx),
    .out_ord_o(m_ord), .out_last_o(m_last), .zero_o(m_zero));

  lzc_iter #(.WIDTH(1), .MODE(1'b0)) u_w1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(w1_ready), .in_data_i(in_data1),
    .out_valid_o(w1_ov), .out_ready_i(out_ready), .out_idx_o(w1_idx),
    .out_ord_o(w1_ord), .out_last_o(w1_last), .zero_o(w1_zero));

  lzc_iter #(.WIDTH(5), .MODE(1'b1)) u_w5 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(w5_ready), .in_data_i(in_data5),
    .out_valid_o(w5_ov), .out_ready_i(out_ready), .out_idx_o(w5_idx),
    .out_ord_o(w5_ord), .out_last_o(w5_last), .zero_o(w5_zero));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point sits 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_l(input string tag, input logic ov, input int idx, input int ord, input logic last);
    check({tag, ".valid"}, 32'(l_ov), 32'(ov));
    check({tag, ".idx"},   32'(l_idx), 32'(idx));
    check({tag, ".ord"},   32'(l_ord), 32'(ord));
    check({tag, ".last"},  32'(l_last), 32'(last));
  endtask

  task automatic chk_m(input string tag, input logic ov, input int idx, input int ord, input logic last);
    check({tag, ".valid"}, 32'(m_ov), 32'(ov));
    check({tag, ".idx"},   32'(m_idx), 32'(idx));
    check({tag, ".ord"},   32'(m_ord), 32'(ord));
    check({tag, ".last"},  32'(m_last), 32'(last));
  endtask

  int exp_l [3] = '{2, 5, 7};
  int exp_m [3] = '{7, 5, 2};

  initial begin
    // Reset state for every instance.
    do_reset();
    #1;
    chk_l("rst_l8", 1'b0, 0, 0, 1'b0);
    chk_m("rst_m8", 1'b0, 0, 0, 1'b0);
    check("rst_l8.zero", 32'(l_zero), 32'd0);
    check("rst_m8.zero", 32'(m_zero), 32'd0);
    check("rst_l8.ready", 32'(l_ready), 32'd1);
    check("rst_m8.ready", 32'(m_ready), 32'd1);
    check("rst_w1.valid", 32'(w1_ov), 32'd0);
    check("rst_w1.zero", 32'(w1_zero), 32'd0);
    check("rst_w1.ready", 32'(w1_ready), 32'd1);
    check("rst_w5.valid", 32'(w5_ov), 32'd0);
    check("rst_w5.zero", 32'(w5_zero), 32'd0);
    check("rst_w5.ready", 32'(w5_ready), 32'd1);

    // 8'b1010_0100 at full throughput, both orders.
    in_valid = 1'b1;
    in_data8 = 8'hA4;
    #1;
    check("a4.in_ready", 32'(l_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_l($sformatf("a4_l8.b%0d", k), 1'b1, exp_l[k], k, k == 2);
      chk_m($sformatf("a4_m8.b%0d", k), 1'b1, exp_m[k], k, k == 2);
      tick();
    end
    chk_l("a4_l8.done", 1'b0, 0, 0, 1'b0);
    check("a4_l8.ready_after", 32'(l_ready), 32'd1);

    // MSB-first with backpressure on idx 5.
    do_reset();
    in_valid = 1'b1;
    in_data8 = 8'hA4;
    tick();
    in_valid = 1'b0;
    chk_m("bp.b0", 1'b1, 7, 0, 1'b0);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_m($sformatf("bp.hold%0d", k), 1'b1, 5, 1, 1'b0);
      tick();
    end
    chk_m("bp.hold3", 1'b1, 5, 1, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_m("bp.b2", 1'b1, 2, 2, 1'b1);
    tick();
    chk_m("bp.done", 1'b0, 0, 0, 1'b0);

    // Back-to-back: 8'h81 then 8'h10 on the last beat, then 8'h00.
    do_reset();
    in_valid = 1'b1;
    in_data8 = 8'h81;
    tick();
    in_valid = 1'b0;
    chk_l("b2b.b0", 1'b1, 0, 0, 1'b0);
    tick();
    chk_l("b2b.b1", 1'b1, 7, 1, 1'b1);
    in_valid = 1'b1;
    in_data8 = 8'h10;
    #1;
    check("b2b.ready_last", 32'(l_ready), 32'd1);
    tick();
    chk_l("b2b.b2", 1'b1, 4, 0, 1'b1);
    in_data8 = 8'h00;
    #1;
    check("b2b.ready_zero", 32'(l_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b.zero_pulse", 32'(l_zero), 32'd1);
    check("b2b.no_beat", 32'(l_ov), 32'd0);
    tick();
    check("b2b.zero_end", 32'(l_zero), 32'd0);
    check("b2b.still_idle", 32'(l_ov), 32'd0);

    // All-zero vector while idle.
    do_reset();
    in_valid = 1'b1;
    in_data8 = 8'h00;
    #1;
    check("zv.ready_pre", 32'(l_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("zv.zero", 32'(l_zero), 32'd1);
    check("zv.valid", 32'(l_ov), 32'd0);
    check("zv.ready", 32'(l_ready), 32'd1);
    tick();
    check("zv.zero_end", 32'(l_zero), 32'd0);
    check("zv.valid_end", 32'(l_ov), 32'd0);

    // Flush after three beats of 8'hFF, then 8'h02.
    do_reset();
    in_valid = 1'b1;
    in_data8 = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk_l("fl.pre", 1'b1, 3, 3, 1'b0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data8 = 8'h40;
    #1;
    check("fl.ready", 32'(l_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk_l("fl.post", 1'b0, 0, 0, 1'b0);
    in_data8 = 8'h02;
    tick();
    in_valid = 1'b0;
    chk_l("fl.next", 1'b1, 1, 0, 1'b1);
    tick();
    chk_l("fl.next_done", 1'b0, 0, 0, 1'b0);

    // Same, aborted by reset instead.
    do_reset();
    in_valid = 1'b1;
    in_data8 = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk_l("rs.pre", 1'b1, 3, 3, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data8 = 8'h40;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk_l("rs.post", 1'b0, 0, 0, 1'b0);
    check("rs.zero", 32'(l_zero), 32'd0);
    tick();
    chk_l("rs.quiet", 1'b0, 0, 0, 1'b0);

    // WIDTH=1 single beat and WIDTH=5 MSB-first 5'b10001.
    do_reset();
    in_valid = 1'b1;
    in_data1 = 1'b1;
    in_data5 = 5'b10001;
    tick();
    in_valid = 1'b0;
    check("w1.valid", 32'(w1_ov), 32'd1);
    check("w1.idx", 32'(w1_idx), 32'd0);
    check("w1.ord", 32'(w1_ord), 32'd0);
    check("w1.last", 32'(w1_last), 32'd1);
    check("w5.b0.valid", 32'(w5_ov), 32'd1);
    check("w5.b0.idx", 32'(w5_idx), 32'd4);
    check("w5.b0.ord", 32'(w5_ord), 32'd0);
    check("w5.b0.last", 32'(w5_last), 32'd0);
    tick();
    check("w1.done", 32'(w1_ov), 32'd0);
    check("w5.b1.valid", 32'(w5_ov), 32'd1);
    check("w5.b1.idx", 32'(w5_idx), 32'd0);
    check("w5.b1.ord", 32'(w5_ord), 32'd1);
    check("w5.b1.last", 32'(w5_last), 32'd1);
    tick();
    check("w5.done", 32'(w5_ov), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
